fx2dbl_sched: RTL and testbench
===============================

# fx2dbl_sched

Round-robin scheduler sharing one iterative fixed-point-to-double converter among N_REQ requesters.
- Accepts signed fixed-point samples over per-requester valid/ready handshakes.
- Sequences the converter with a start/done protocol.
- Returns each `fp_double::double` result tagged with the requester ID.
- Guards against a hung converter with a timeout.
- Sits between the fetal-ECG sample producers and the double-precision processing stages.

## Interface
- N_REQ, 4, number of requesters (2..16)
- N_BITS_INT, 32, integer bits of input fixed-point
- N_BITS_FRAC, 16, fractional bits; W = N_BITS_INT+N_BITS_FRAC
- TIMEOUT, 64, max cycles in WAIT before abort (>= 2)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester sample valid
- req_num  in  N_REQ*W  packed signed samples; requester i at bits [i*W +: W]
- req_ready  out  N_REQ  one-hot accept strobe
- conv_start  out  1  one-cycle start pulse to converter
- conv_num  out  W  sample to converter, stable from conv_start until leaving WAIT
- conv_done  in  1  converter result valid, single-cycle pulse
- conv_result  in  64  converter output, type double
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  $clog2(N_REQ)  originating requester
- rsp_num  out  64  result, type double
- rsp_err  out  1  1 = converter timed out
- err_count  out  16  saturating count of timeouts

## Operation
- FSM states:
  - IDLE: if any req_valid, grant the first valid index searching upward (mod N_REQ) from last_grant+1.
    - Assert req_ready[grant] combinationally; the handshake completes that edge.
    - Latch sample and ID.
    - Latched sample == 0: go RESP with rsp_num = +0.0 (all 64 bits 0) and rsp_err = 0. Converter is not started.
    - Otherwise go ISSUE.
  - ISSUE: conv_start = 1 for exactly this cycle; clear wait counter; go WAIT.
  - WAIT: counter increments each cycle.
    - conv_done = 1: latch conv_result into rsp_num; rsp_err = 0; go RESP.
    - Counter reaches TIMEOUT-1 without done: rsp_num = +0.0; rsp_err = 1; err_count +1 (saturates at 0xFFFF); go RESP.
    - conv_done and timeout in the same cycle: done wins, no error.
  - RESP: rsp_valid = 1. On rsp_valid && rsp_ready: last_grant <= rsp_id; go IDLE.
- req_ready stays 0 in all states except IDLE, so there is at most one transaction in flight.
- conv_done outside WAIT is ignored; conv_result is sampled only in WAIT.
- rsp_id, rsp_num and rsp_err hold stable while rsp_valid = 1 and rsp_ready = 0.
- req_valid deasserting while not granted is legal and causes no effect.
- Sign and width handling belong to the converter. The scheduler forwards the W-bit sample unmodified.

## Timing
- Reset values:
  - state IDLE; last_grant = N_REQ-1, so requester 0 has first priority.
  - req_ready 0, conv_start 0, conv_num 0, rsp_valid 0, rsp_id 0, rsp_num 0, rsp_err 0, err_count 0.
- Reset mid-operation (any state) returns to IDLE on the next edge:
  - The pending transaction is dropped with no response.
  - err_count is cleared.
  - A late conv_done is ignored.
- Accept at edge T:
  - conv_start high during cycle T+1.
  - conv_done seen at cycle T+1+k (k ≥ 1) gives rsp_valid high from cycle T+2+k.
- Zero sample accepted at edge T: rsp_valid high from cycle T+1.
- Timeout: rsp_valid high TIMEOUT+1 cycles after conv_start.
- Minimum spacing between accepts is k+3 cycles with rsp_ready tied high. The IDLE cycle between transactions is mandatory.
- All outputs are registered except req_ready, which is decoded from state and arbiter.

## Test plan
- Single request: req_num[0] = 48'h0000_0001_0000 (1.0), bench converter k = 5 returning 64'h3FF0_0000_0000_0000 -> conv_start 1 cycle after accept, rsp_valid 7 cycles after accept, rsp_id 0, rsp_num 3FF0000000000000, rsp_err 0.
- Round robin: all four req_valid held high, rsp_ready = 1 -> grant order 0,1,2,3,0,1; each req_ready pulses exactly once per grant.
- Zero bypass: req_num[2] = 0 -> conv_start never asserted, rsp_valid one cycle after accept, rsp_num = 0, rsp_id 2.
- Timeout: converter never asserts done, TIMEOUT = 64 -> rsp_err 1, rsp_num 0, err_count 1; a later conv_done pulse in IDLE causes no response.
- Backpressure: rsp_ready low for 10 cycles in RESP -> rsp_* stable, all req_ready 0; response taken on the first cycle rsp_ready = 1.
- Reset in WAIT: assert rst for 1 cycle -> all outputs at reset values next cycle, no rsp_valid for the aborted request, requester 0 granted first afterwards.

Source files
------------

// File: rtl/fx2dbl_sched_if.sv
// Bundle of requester, converter and response signals for fx2dbl_sched.
// slave is the scheduler's view; master is the surrounding system's view.
interface fx2dbl_sched_if #(
  parameter int N_REQ       = 4,
  parameter int N_BITS_INT  = 32,
  parameter int N_BITS_FRAC = 16
);
  localparam int W   = N_BITS_INT + N_BITS_FRAC;
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_num;
  logic [N_REQ-1:0]   req_ready;

  logic               conv_start;
  logic [W-1:0]       conv_num;
  logic               conv_done;
  logic [63:0]        conv_result;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [63:0]        rsp_num;
  logic               rsp_err;
  logic [15:0]        err_count;

  modport slave (
    input  req_valid, req_num, conv_done, conv_result, rsp_ready,
    output req_ready, conv_start, conv_num, rsp_valid, rsp_id, rsp_num, rsp_err, err_count
  );

  modport master (
    output req_valid, req_num, conv_done, conv_result, rsp_ready,
    input  req_ready, conv_start, conv_num, rsp_valid, rsp_id, rsp_num, rsp_err, err_count
  );
endinterface

// File: rtl/fx2dbl_sched.sv
// Round-robin scheduler sharing one iterative fixed-to-double converter among
// N_REQ requesters, with zero bypass, converter timeout and tagged responses.
module fx2dbl_sched #(
  parameter int N_REQ       = 4,
  parameter int N_BITS_INT  = 32,
  parameter int N_BITS_FRAC = 16,
  parameter int TIMEOUT     = 64
) (
  input logic           clk,
  input logic           rst,
  fx2dbl_sched_if.slave bus
);
  localparam int W   = N_BITS_INT + N_BITS_FRAC;
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(TIMEOUT);

  localparam logic [IDW-1:0] LAST_GRANT_RST = IDW'(N_REQ - 1);
  localparam logic [CW-1:0]  CNT_LAST       = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_ONE        = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e         state_q;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] rsp_id_q;
  logic [W-1:0]   conv_num_q;
  logic           conv_start_q;
  logic           rsp_valid_q;
  logic [63:0]    rsp_num_q;
  logic           rsp_err_q;
  logic [15:0]    err_count_q;
  logic [CW-1:0]  wait_cnt_q;

  logic [IDW-1:0]   grant_s;
  logic             grant_vld_s;
  logic [W-1:0]     grant_num_s;
  logic [N_REQ-1:0] req_ready_s;

  // Arbiter: walk downward so the smallest offset from last_grant+1 wins.
  always_comb begin
    int idx_v;
    idx_v       = 0;
    grant_s     = {IDW{1'b0}};
    grant_vld_s = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx_v = (int'(last_grant_q) + i) % N_REQ;
      if (bus.req_valid[idx_v[IDW-1:0]]) begin
        grant_vld_s = 1'b1;
        grant_s     = idx_v[IDW-1:0];
      end else begin
        grant_vld_s = grant_vld_s;
        grant_s     = grant_s;
      end
    end
  end

  assign grant_num_s = bus.req_num[int'(grant_s)*W +: W];

  // Accept strobe: only in IDLE, one-hot on the granted requester.
  always_comb begin
    if ((state_q == IDLE) && grant_vld_s) begin
      req_ready_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_s;
    end else begin
      req_ready_s = {N_REQ{1'b0}};
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_GRANT_RST;
      rsp_id_q     <= {IDW{1'b0}};
      conv_num_q   <= {W{1'b0}};
      conv_start_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_num_q    <= 64'd0;
      rsp_err_q    <= 1'b0;
      err_count_q  <= 16'd0;
      wait_cnt_q   <= {CW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          conv_start_q <= 1'b0;
          if (grant_vld_s) begin
            rsp_id_q   <= grant_s;
            conv_num_q <= grant_num_s;
            // A zero sample converts to +0.0 without touching the converter.
            if (grant_num_s == {W{1'b0}}) begin
              rsp_num_q   <= 64'd0;
              rsp_err_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              conv_start_q <= 1'b1;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          conv_start_q <= 1'b0;
          wait_cnt_q   <= {CW{1'b0}};
          state_q      <= WAIT;
        end
        WAIT: begin
          if (bus.conv_done) begin
            rsp_num_q   <= bus.conv_result;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (wait_cnt_q == CNT_LAST) begin
            rsp_num_q   <= 64'd0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            if (err_count_q != 16'hFFFF) begin
              err_count_q <= err_count_q + 16'd1;
            end
            state_q     <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_ONE;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
            last_grant_q <= rsp_id_q;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.conv_start = conv_start_q;
  assign bus.conv_num   = conv_num_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_num    = rsp_num_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_fx2dbl_sched.sv
// Scoreboard bench for fx2dbl_sched: directed requests, a behavioural
// converter with lookup results, and a monitor checking every response.
module tb_fx2dbl_sched;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] num;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fx2dbl_sched_if #(.N_REQ(N_REQ), .N_BITS_INT(32), .N_BITS_FRAC(16)) bus ();

  fx2dbl_sched #(
    .N_REQ(N_REQ), .N_BITS_INT(32), .N_BITS_FRAC(16), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  rsp_t exp_q[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0;
  int   n_grants = 0, n_starts = 0, n_rsp = 0;
  int   acc_cyc = 0, start_cyc = 0, rise_cyc = 0;
  logic [47:0] acc_sample = 48'd0;
  logic prev_valid = 1'b0;
  int   conv_k = 2;
  logic conv_hang = 1'b0;
  int   late_cnt = 0;

  localparam logic [47:0] FX_ONE  = 48'h0000_0001_0000;
  localparam logic [47:0] FX_TWO  = 48'h0000_0002_0000;
  localparam logic [47:0] FX_MONE = 48'hFFFF_FFFF_0000;
  localparam logic [47:0] FX_HALF = 48'h0000_0000_8000;
  localparam logic [63:0] D_ONE   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] D_TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] D_MONE  = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] D_HALF  = 64'h3FE0_0000_0000_0000;

  function automatic logic [63:0] conv_lut(input logic [47:0] s);
    case (s)
      FX_ONE:  return D_ONE;
      FX_TWO:  return D_TWO;
      FX_MONE: return D_MONE;
      FX_HALF: return D_HALF;
      default: return 64'h7FF8_0000_0000_0000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [63:0] num, input logic err);
    rsp_t e;
    e.id = id; e.num = num; e.err = err;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Converter model: answers conv_k cycles after start unless hung; can inject a stray done.
  initial begin
    int late_seen;
    late_seen = 0;
    bus.conv_done   = 1'b0;
    bus.conv_result = 64'd0;
    forever begin
      @(negedge clk);
      if (bus.conv_start && !conv_hang) begin
        repeat (conv_k) @(posedge clk);
        #1 bus.conv_done = 1'b1;
        bus.conv_result = conv_lut(bus.conv_num);
        @(posedge clk);
        #1 bus.conv_done = 1'b0;
      end else if (late_cnt != late_seen) begin
        late_seen = late_cnt;
        @(posedge clk);
        #1 bus.conv_done = 1'b1;
        bus.conv_result = D_ONE;
        @(posedge clk);
        #1 bus.conv_done = 1'b0;
      end
    end
  end

  // Monitor: records timing and pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst) begin
      if (bus.req_ready != 4'b0000) begin
        chk("req_ready_onehot", 64'($onehot(bus.req_ready)), 64'd1);
        n_grants++;
        acc_cyc = cyc + 1;
        for (int i = 0; i < N_REQ; i++) begin
          if (bus.req_ready[i]) acc_sample = bus.req_num[i*48 +: 48];
        end
      end
      if (bus.conv_start) begin
        n_starts++;
        start_cyc = cyc;
        chk("conv_num", 64'(bus.conv_num), 64'(acc_sample));
      end
      if (bus.rsp_valid && !prev_valid) rise_cyc = cyc;
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rsp: got id %0d num %h err %0d, required none", bus.rsp_id, bus.rsp_num, bus.rsp_err);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
          chk("rsp_num", bus.rsp_num, e.num);
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        end
      end
    end
    prev_valid = bus.rsp_valid;
  end

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_conv_start"}, 64'(bus.conv_start), 64'd0);
    chk({tag, "_conv_num"}, 64'(bus.conv_num), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'd0);
    chk({tag, "_rsp_num"}, bus.rsp_num, 64'd0);
    chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
    chk({tag, "_err_count"}, 64'(bus.err_count), 64'd0);
  endtask

  task automatic wait_grants(input int target, input string nm);
    int n;
    n = 0;
    while (n_grants < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n_grants < target) bound_fail(nm);
    #1;
  endtask

  task automatic issue(input int idx, input logic [47:0] s, input string nm);
    int base;
    base = n_grants;
    bus.req_num[idx*48 +: 48] = s;
    bus.req_valid[idx] = 1'b1;
    wait_grants(base + 1, nm);
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) bound_fail(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, s0, r0, n;
    bus.req_valid = 4'b0000;
    bus.req_num   = {N_REQ*48{1'b0}};
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;

    // Round robin from reset: 0,1,2,3,0,1
    conv_k = 2;
    push_exp(2'd0, D_ONE, 1'b0);  push_exp(2'd1, D_TWO, 1'b0);
    push_exp(2'd2, D_MONE, 1'b0); push_exp(2'd3, D_HALF, 1'b0);
    push_exp(2'd0, D_ONE, 1'b0);  push_exp(2'd1, D_TWO, 1'b0);
    base = n_grants;
    bus.req_num   = {FX_HALF, FX_MONE, FX_TWO, FX_ONE};
    bus.req_valid = 4'b1111;
    wait_grants(base + 6, "rr_grants_wait");
    bus.req_valid = 4'b0000;
    drain("rr_drain");
    chk("rr_grant_count", 64'(n_grants - base), 64'd6);

    // Single request, converter latency 5
    conv_k = 5;
    push_exp(2'd0, D_ONE, 1'b0);
    issue(0, FX_ONE, "single_accept");
    drain("single_drain");
    chk("single_start_lat", 64'(start_cyc - acc_cyc), 64'd0);
    chk("single_rsp_lat", 64'(rise_cyc - acc_cyc), 64'd6);

    // Zero bypass on requester 2
    push_exp(2'd2, 64'd0, 1'b0);
    s0 = n_starts;
    issue(2, 48'd0, "zero_accept");
    drain("zero_drain");
    chk("zero_no_start", 64'(n_starts - s0), 64'd0);
    chk("zero_rsp_lat", 64'(rise_cyc - acc_cyc), 64'd0);

    // Timeout on requester 1, then a stray done in IDLE
    conv_hang = 1'b1;
    push_exp(2'd1, 64'd0, 1'b1);
    issue(1, FX_TWO, "timeout_accept");
    drain("timeout_drain");
    chk("timeout_lat", 64'(rise_cyc - start_cyc), 64'(TIMEOUT + 1));
    chk("timeout_err_count", 64'(bus.err_count), 64'd1);
    r0 = n_rsp;
    late_cnt++;
    repeat (6) @(posedge clk);
    #1;
    chk("late_done_no_rsp", 64'(n_rsp - r0), 64'd0);
    chk("late_done_valid", 64'(bus.rsp_valid), 64'd0);
    conv_hang = 1'b0;

    // Backpressure: requester 3 held in RESP while requester 0 waits
    conv_k = 4;
    bus.rsp_ready = 1'b0;
    push_exp(2'd3, D_HALF, 1'b0);
    push_exp(2'd0, D_ONE, 1'b0);
    bus.req_num[0 +: 48] = FX_ONE;
    bus.req_valid[0] = 1'b1;
    issue(3, FX_HALF, "bp_accept");
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) bound_fail("bp_rsp_wait");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_id", 64'(bus.rsp_id), 64'd3);
      chk("bp_num", bus.rsp_num, D_HALF);
      chk("bp_err", 64'(bus.rsp_err), 64'd0);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_taken_valid", 64'(bus.rsp_valid), 64'd0);
    chk("bp_next_grant", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    drain("bp_drain");

    // Reset while waiting on a hung converter
    conv_hang = 1'b1;
    issue(2, FX_ONE, "rstwait_accept");
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("after_rst");
    conv_hang = 1'b0;
    conv_k = 3;
    r0 = n_rsp;
    late_cnt++;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_rsp", 64'(n_rsp - r0), 64'd0);
    push_exp(2'd0, D_ONE, 1'b0);
    push_exp(2'd3, D_MONE, 1'b0);
    base = n_grants;
    bus.req_num[0 +: 48]   = FX_ONE;
    bus.req_num[144 +: 48] = FX_MONE;
    bus.req_valid = 4'b1001;
    wait_grants(base + 1, "rst_grant0_wait");
    bus.req_valid[0] = 1'b0;
    wait_grants(base + 2, "rst_grant3_wait");
    bus.req_valid[3] = 1'b0;
    drain("rst_drain");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
